// File: rtl/id_ex_stage_reg_if.sv
// -----------------------------------------------------------------------------
// id_ex_stage_reg_if
//   Bundle of every signal exchanged between the ID/EX pipeline register and its
//   neighbours: the decode slot (id_*), the write-back port (wb_*), the EX-stage
//   control inputs (ex_flush / ex_hold) and the registered ID/EX outputs.
//
//   Handshake: id_valid marks a real instruction in the decode slot. stall_o acts
//   as an inverted ready. While stall_o=1 the upstream stages must hold PC and
//   IF/ID so that the same instruction re-presents on the next cycle. An
//   instruction is accepted on a rising edge where id_valid=1, stall_o=0 and
//   ex_flush=0.
//
//   Modports
//     master : the surrounding pipeline. It drives id_*, wb_*, ex_flush and
//              ex_hold, and observes stall_o, id_ex_* and stall_count.
//     slave  : the ID/EX register itself.
// -----------------------------------------------------------------------------
interface id_ex_stage_reg_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  // decode slot
  logic                  id_valid;
  logic [XLEN-1:0]       id_pc;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic [XLEN-1:0]       id_rs1_data;
  logic [XLEN-1:0]       id_rs2_data;
  logic [XLEN-1:0]       id_imm;
  logic                  id_regWrite;
  logic                  id_memRead;
  logic                  id_memWrite;
  logic [3:0]            id_aluOp;

  // write-back port
  logic                  wb_regWrite;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]       wb_data;

  // EX-stage control
  logic                  ex_flush;
  logic                  ex_hold;

  // outputs
  logic                  stall_o;
  logic                  id_ex_valid;
  logic [XLEN-1:0]       id_ex_pc;
  logic [XLEN-1:0]       id_ex_rs1_data;
  logic [XLEN-1:0]       id_ex_rs2_data;
  logic [XLEN-1:0]       id_ex_imm;
  logic [REG_ADDR_W-1:0] id_ex_rs1;
  logic [REG_ADDR_W-1:0] id_ex_rs2;
  logic [REG_ADDR_W-1:0] id_ex_rd;
  logic                  id_ex_regWrite;
  logic                  id_ex_memRead;
  logic                  id_ex_memWrite;
  logic [3:0]            id_ex_aluOp;
  logic [31:0]           stall_count;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_rs1_data, id_rs2_data, id_imm, id_regWrite, id_memRead,
           id_memWrite, id_aluOp, wb_regWrite, wb_rd, wb_data, ex_flush, ex_hold,
    input  stall_o, id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data,
           id_ex_imm, id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_regWrite,
           id_ex_memRead, id_ex_memWrite, id_ex_aluOp, stall_count
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_rs1_data, id_rs2_data, id_imm, id_regWrite, id_memRead,
           id_memWrite, id_aluOp, wb_regWrite, wb_rd, wb_data, ex_flush, ex_hold,
    output stall_o, id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data,
           id_ex_imm, id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_regWrite,
           id_ex_memRead, id_ex_memWrite, id_ex_aluOp, stall_count
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_reg
//   ID/EX pipeline register with load-use hazard detection, bubble insertion,
//   EX-driven flush/hold and WB-to-ID register-file write-through.
//
//   Ports
//     clk  : rising-edge clock
//     rst  : synchronous, active-high reset (all registers cleared)
//     bus  : id_ex_stage_reg_if.slave. It carries the id_* decode inputs, the
//            wb_* write-back port, ex_flush/ex_hold, and the outputs stall_o,
//            id_ex_* and stall_count.
//
//   Handshake: stall_o is an inverted ready for the decode slot. While it is 1,
//   the decode instruction is not consumed and must re-present next cycle.
//
//   Optional feature: macro STALL_CNT_EN. When it is defined, stall_count counts
//   the load-use bubbles (it wraps and is cleared by rst). When it is undefined,
//   stall_count is tied to zero and no counter is built.
//
//   Debug: upd_sel_dbg names the update action chosen for the coming edge.
// -----------------------------------------------------------------------------
module id_ex_stage_reg #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  id_ex_stage_reg_if.slave  bus,
  output logic [2:0]        upd_sel_dbg
);

  // Update action for the next rising edge. The order follows the priority
  // used when several conditions hold at once.
  typedef enum logic [2:0] {
    UPD_RESET   = 3'd0,
    UPD_FLUSH   = 3'd1,
    UPD_HOLD    = 3'd2,
    UPD_BUBBLE  = 3'd3,
    UPD_CAPTURE = 3'd4
  } upd_e;

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  logic                  valid_q;
  logic [XLEN-1:0]       pc_q;
  logic [XLEN-1:0]       rs1_data_q;
  logic [XLEN-1:0]       rs2_data_q;
  logic [XLEN-1:0]       imm_q;
  logic [REG_ADDR_W-1:0] rs1_q;
  logic [REG_ADDR_W-1:0] rs2_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  reg_write_q;
  logic                  mem_read_q;
  logic                  mem_write_q;
  logic [3:0]            alu_op_q;

  // ---------------------------------------------------------------------------
  // Next-state values
  // ---------------------------------------------------------------------------
  logic                  valid_d;
  logic [XLEN-1:0]       pc_d;
  logic [XLEN-1:0]       rs1_data_d;
  logic [XLEN-1:0]       rs2_data_d;
  logic [XLEN-1:0]       imm_d;
  logic [REG_ADDR_W-1:0] rs1_d;
  logic [REG_ADDR_W-1:0] rs2_d;
  logic [REG_ADDR_W-1:0] rd_d;
  logic                  reg_write_d;
  logic                  mem_read_d;
  logic                  mem_write_d;
  logic [3:0]            alu_op_d;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  logic rs1_match;
  logic rs2_match;
  logic hz;
  upd_e upd_sel;

  // A load in EX whose result the decode instruction needs cannot be
  // forwarded in time, so one bubble is inserted. Loads to x0 never create a
  // dependency.
  assign rs1_match = bus.id_uses_rs1 && (bus.id_rs1 == rd_q);
  assign rs2_match = bus.id_uses_rs2 && (bus.id_rs2 == rd_q);
  assign hz        = bus.id_valid && valid_q && mem_read_q &&
                     (rd_q != '0) && (rs1_match || rs2_match);

  // A flush kills the decode instruction, so there is no reason to hold
  // upstream during a flush.
  assign bus.stall_o = (hz || bus.ex_hold) && !bus.ex_flush;

  // ---------------------------------------------------------------------------
  // WB-to-ID write-through: the register file is written at the end of this
  // cycle, so the value read in decode would be stale. Writes to x0 are
  // ignored because x0 always reads as zero.
  // ---------------------------------------------------------------------------
  logic            wb_hits_rs1;
  logic            wb_hits_rs2;
  logic [XLEN-1:0] rs1_data_fwd;
  logic [XLEN-1:0] rs2_data_fwd;

  assign wb_hits_rs1  = bus.wb_regWrite && (bus.wb_rd != '0) &&
                        (bus.wb_rd == bus.id_rs1);
  assign wb_hits_rs2  = bus.wb_regWrite && (bus.wb_rd != '0) &&
                        (bus.wb_rd == bus.id_rs2);
  assign rs1_data_fwd = wb_hits_rs1 ? bus.wb_data : bus.id_rs1_data;
  assign rs2_data_fwd = wb_hits_rs2 ? bus.wb_data : bus.id_rs2_data;

  // ---------------------------------------------------------------------------
  // Update selection
  // ---------------------------------------------------------------------------
  always_comb begin
    upd_sel = UPD_CAPTURE;
    if (rst)              upd_sel = UPD_RESET;
    else if (bus.ex_flush) upd_sel = UPD_FLUSH;
    else if (bus.ex_hold)  upd_sel = UPD_HOLD;
    else if (hz)           upd_sel = UPD_BUBBLE;
  end

  assign upd_sel_dbg = upd_sel;

  // ---------------------------------------------------------------------------
  // Next-state values. Reset, flush and bubble all clear every field: the
  // control bits of a bubble must be zero, and the data is driven to zero as
  // well so that the bubble is deterministic.
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_d     = 1'b0;
    pc_d        = '0;
    rs1_data_d  = '0;
    rs2_data_d  = '0;
    imm_d       = '0;
    rs1_d       = '0;
    rs2_d       = '0;
    rd_d        = '0;
    reg_write_d = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    alu_op_d    = 4'h0;
    unique case (upd_sel)
      UPD_HOLD: begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        alu_op_d    = alu_op_q;
      end
      UPD_CAPTURE: begin
        valid_d     = bus.id_valid;
        pc_d        = bus.id_pc;
        rs1_data_d  = rs1_data_fwd;
        rs2_data_d  = rs2_data_fwd;
        imm_d       = bus.id_imm;
        rs1_d       = bus.id_rs1;
        rs2_d       = bus.id_rs2;
        rd_d        = bus.id_rd;
        // An empty decode slot must never look like a writer or a memory op.
        reg_write_d = bus.id_valid && bus.id_regWrite;
        mem_read_d  = bus.id_valid && bus.id_memRead;
        mem_write_d = bus.id_valid && bus.id_memWrite;
        alu_op_d    = bus.id_valid ? bus.id_aluOp : 4'h0;
      end
      default: ; // reset / flush / bubble: all-zero defaults
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline register. Reset is folded into upd_sel, so this block simply
  // loads the next-state values.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    valid_q     <= valid_d;
    pc_q        <= pc_d;
    rs1_data_q  <= rs1_data_d;
    rs2_data_q  <= rs2_data_d;
    imm_q       <= imm_d;
    rs1_q       <= rs1_d;
    rs2_q       <= rs2_d;
    rd_q        <= rd_d;
    reg_write_q <= reg_write_d;
    mem_read_q  <= mem_read_d;
    mem_write_q <= mem_write_d;
    alu_op_q    <= alu_op_d;
  end

  // ---------------------------------------------------------------------------
  // Load-use bubble counter
  // ---------------------------------------------------------------------------
`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Counts only hazard bubbles. Flush bubbles and hold cycles are not counted.
  // The counter wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst)                        stall_cnt_q <= 32'h0;
    else if (upd_sel == UPD_BUBBLE) stall_cnt_q <= stall_cnt_q + 32'h1;
  end

  assign bus.stall_count = stall_cnt_q;
`else
  assign bus.stall_count = 32'h0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.id_ex_valid    = valid_q;
  assign bus.id_ex_pc       = pc_q;
  assign bus.id_ex_rs1_data = rs1_data_q;
  assign bus.id_ex_rs2_data = rs2_data_q;
  assign bus.id_ex_imm      = imm_q;
  assign bus.id_ex_rs1      = rs1_q;
  assign bus.id_ex_rs2      = rs2_q;
  assign bus.id_ex_rd       = rd_q;
  assign bus.id_ex_regWrite = reg_write_q;
  assign bus.id_ex_memRead  = mem_read_q;
  assign bus.id_ex_memWrite = mem_write_q;
  assign bus.id_ex_aluOp    = alu_op_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage_reg
//   Self-checking bench for id_ex_stage_reg. Directed scenarios are followed by
//   a randomized run. Each cycle is compared against a reference model that
//   describes the stage in pipeline terms: the instruction sitting in EX, the
//   load-use rule, the register-file read with write-through, and the
//   flush/hold/stall priority.
// -----------------------------------------------------------------------------
module tb_id_ex_stage_reg;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] upd_sel_dbg;

  always #5 clk = ~clk;

  id_ex_stage_reg_if #(.XLEN(32), .REG_ADDR_W(5)) bus_if ();

  id_ex_stage_reg #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .upd_sel_dbg (upd_sel_dbg)
  );

  // ---------------------------------------------------------------------------
  // Stimulus and model types
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        rst;
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2;
    logic [31:0] d1, d2, imm;
    logic        rw, mr, mw;
    logic [3:0]  op;
    logic        wbw;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic        flush, hold;
  } stim_t;

  // The instruction currently occupying EX, as seen by execute.
  typedef struct {
    logic        valid;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mr, mw;
    logic [3:0]  op;
  } ex_slot_t;

  ex_slot_t    ex_slot;       // model of the EX slot
  int unsigned bubbles;       // model count of load-use bubbles
  ex_slot_t    exp_q[$];      // scoreboard: expected EX slot after each edge
  logic [31:0] exp_cnt_q[$];  // scoreboard: expected stall_count after each edge

  int tests = 0;
  int fails = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic ex_slot_t empty_slot();
    ex_slot_t e;
    e = '{valid: 1'b0, pc: 32'h0, d1: 32'h0, d2: 32'h0, imm: 32'h0,
          rs1: 5'h0, rs2: 5'h0, rd: 5'h0, rw: 1'b0, mr: 1'b0, mw: 1'b0,
          op: 4'h0};
    return e;
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s = '{rst: 1'b0, valid: 1'b0, pc: 32'h0, rs1: 5'h0, rs2: 5'h0, rd: 5'h0,
          u1: 1'b0, u2: 1'b0, d1: 32'h0, d2: 32'h0, imm: 32'h0, rw: 1'b0,
          mr: 1'b0, mw: 1'b0, op: 4'h0, wbw: 1'b0, wbrd: 5'h0, wbd: 32'h0,
          flush: 1'b0, hold: 1'b0};
    return s;
  endfunction

  // Does the decode instruction need the value a load in EX has not yet
  // fetched?
  function automatic logic load_use(stim_t s);
    if (!(s.valid && ex_slot.valid && ex_slot.mr) || ex_slot.rd == 5'd0)
      return 1'b0;
    return (s.u1 && s.rs1 == ex_slot.rd) || (s.u2 && s.rs2 == ex_slot.rd);
  endfunction

  // Register read in decode. A value being written back this cycle is the
  // current one; x0 is never written.
  function automatic logic [31:0] rf_read(stim_t s, logic [4:0] idx,
                                          logic [31:0] rf_val);
    if (s.wbw && s.wbrd != 5'd0 && s.wbrd == idx) return s.wbd;
    return rf_val;
  endfunction

  function automatic logic exp_stall(stim_t s);
    if (s.flush) return 1'b0;
    return s.hold || load_use(s);
  endfunction

  // Advance the model by one rising edge and queue the expected outcome.
  task automatic model_edge(input stim_t s);
    logic lu;
    lu = load_use(s);
    if (s.rst) begin
      ex_slot = empty_slot();
      bubbles = 0;
    end else if (s.flush) begin
      ex_slot = empty_slot();
    end else if (s.hold) begin
      // EX is busy; nothing moves
    end else if (lu) begin
      ex_slot = empty_slot();
      bubbles = bubbles + 1;
    end else begin
      ex_slot.valid = s.valid;
      ex_slot.pc    = s.pc;
      ex_slot.d1    = rf_read(s, s.rs1, s.d1);
      ex_slot.d2    = rf_read(s, s.rs2, s.d2);
      ex_slot.imm   = s.imm;
      ex_slot.rs1   = s.rs1;
      ex_slot.rs2   = s.rs2;
      ex_slot.rd    = s.rd;
      ex_slot.rw    = s.valid & s.rw;
      ex_slot.mr    = s.valid & s.mr;
      ex_slot.mw    = s.valid & s.mw;
      ex_slot.op    = s.valid ? s.op : 4'h0;
    end
    exp_q.push_back(ex_slot);
`ifdef STALL_CNT_EN
    exp_cnt_q.push_back(32'(bubbles));
`else
    exp_cnt_q.push_back(32'h0);
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string step);
    ex_slot_t    e;
    logic [31:0] c;
    e = exp_q.pop_front();
    c = exp_cnt_q.pop_front();
    check({step, ".valid"},    32'(bus_if.id_ex_valid),    32'(e.valid));
    check({step, ".pc"},       bus_if.id_ex_pc,            e.pc);
    check({step, ".rs1_data"}, bus_if.id_ex_rs1_data,      e.d1);
    check({step, ".rs2_data"}, bus_if.id_ex_rs2_data,      e.d2);
    check({step, ".imm"},      bus_if.id_ex_imm,           e.imm);
    check({step, ".rs1"},      32'(bus_if.id_ex_rs1),      32'(e.rs1));
    check({step, ".rs2"},      32'(bus_if.id_ex_rs2),      32'(e.rs2));
    check({step, ".rd"},       32'(bus_if.id_ex_rd),       32'(e.rd));
    check({step, ".regWrite"}, 32'(bus_if.id_ex_regWrite), 32'(e.rw));
    check({step, ".memRead"},  32'(bus_if.id_ex_memRead),  32'(e.mr));
    check({step, ".memWrite"}, 32'(bus_if.id_ex_memWrite), 32'(e.mw));
    check({step, ".aluOp"},    32'(bus_if.id_ex_aluOp),    32'(e.op));
    check({step, ".stall_count"}, bus_if.stall_count,      c);
  endtask

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic drive(input stim_t s);
    rst                = s.rst;
    bus_if.id_valid    = s.valid;
    bus_if.id_pc       = s.pc;
    bus_if.id_rs1      = s.rs1;
    bus_if.id_rs2      = s.rs2;
    bus_if.id_uses_rs1 = s.u1;
    bus_if.id_uses_rs2 = s.u2;
    bus_if.id_rd       = s.rd;
    bus_if.id_rs1_data = s.d1;
    bus_if.id_rs2_data = s.d2;
    bus_if.id_imm      = s.imm;
    bus_if.id_regWrite = s.rw;
    bus_if.id_memRead  = s.mr;
    bus_if.id_memWrite = s.mw;
    bus_if.id_aluOp    = s.op;
    bus_if.wb_regWrite = s.wbw;
    bus_if.wb_rd       = s.wbrd;
    bus_if.wb_data     = s.wbd;
    bus_if.ex_flush    = s.flush;
    bus_if.ex_hold     = s.hold;
  endtask

  // One cycle: drive on the falling edge, check the combinational stall_o
  // before the rising edge, then check the registers just after it.
  task automatic step(input string tag, input stim_t s);
    @(negedge clk);
    drive(s);
    #1;
    check({tag, ".stall_o"}, 32'(bus_if.stall_o), 32'(exp_stall(s)));
    @(posedge clk);
    model_edge(s);
    #1;
    check_outputs(tag);
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s       = idle_stim();
    s.rst   = ($urandom_range(0, 63) == 0);
    s.valid = ($urandom_range(0, 7) != 0);
    s.pc    = $urandom;
    s.rs1   = 5'($urandom_range(0, 3));
    s.rs2   = 5'($urandom_range(0, 3));
    s.rd    = 5'($urandom_range(0, 3));
    s.u1    = 1'($urandom);
    s.u2    = 1'($urandom);
    s.d1    = $urandom;
    s.d2    = $urandom;
    s.imm   = $urandom;
    s.rw    = 1'($urandom);
    s.mr    = ($urandom_range(0, 2) == 0);
    s.mw    = ($urandom_range(0, 3) == 0);
    s.op    = 4'($urandom);
    s.wbw   = 1'($urandom);
    s.wbrd  = 5'($urandom_range(0, 3));
    s.wbd   = $urandom;
    s.flush = ($urandom_range(0, 15) == 0);
    s.hold  = ($urandom_range(0, 9) == 0);
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    stim_t s, lw, add;
    ex_slot = empty_slot();
    bubbles = 0;
    drive(idle_stim());

    // Reset held for two cycles, including a cycle with a flush request.
    s = idle_stim(); s.rst = 1'b1; s.valid = 1'b1; s.rd = 5'd9; s.rw = 1'b1;
    step("reset0", s);
    s.flush = 1'b1;
    step("reset1", s);
    step("idle", idle_stim());

    // Load-use: lw x5 in EX, then add x6,x5,x7 stalls for one bubble.
    lw = idle_stim(); lw.valid = 1'b1; lw.pc = 32'h100; lw.rs1 = 5'd2;
    lw.u1 = 1'b1; lw.rd = 5'd5; lw.rw = 1'b1; lw.mr = 1'b1; lw.imm = 32'h10;
    lw.op = 4'h1;
    step("lw_x5", lw);
    add = idle_stim(); add.valid = 1'b1; add.pc = 32'h104; add.rs1 = 5'd5;
    add.rs2 = 5'd7; add.u1 = 1'b1; add.rd = 5'd6; add.rw = 1'b1;
    add.d1 = 32'h1111; add.d2 = 32'h2222; add.op = 4'h2;
    step("add_stall", add);
    step("add_capture", add);

    // Load to x0 never stalls.
    lw.rd = 5'd0; lw.pc = 32'h108;
    step("lw_x0", lw);
    add.rs1 = 5'd0; add.pc = 32'h10c;
    step("add_x0", add);

    // Write-through on rs2; write to x0 is not bypassed on rs1.
    s = idle_stim(); s.valid = 1'b1; s.pc = 32'h110; s.rs1 = 5'd0; s.rs2 = 5'd3;
    s.u1 = 1'b1; s.u2 = 1'b1; s.rd = 5'd4; s.rw = 1'b1; s.d1 = 32'h0;
    s.d2 = 32'h0; s.wbw = 1'b1; s.wbrd = 5'd3; s.wbd = 32'hDEADBEEF;
    step("wb_through", s);
    s.rs1 = 5'd0; s.d1 = 32'h5A5A; s.wbrd = 5'd0; s.wbd = 32'hCAFEF00D;
    step("wb_x0", s);

    // Flush together with a load-use hazard: flush wins, no bubble counted.
    lw.rd = 5'd5; lw.pc = 32'h114;
    step("lw_x5_again", lw);
    add.rs1 = 5'd5; add.pc = 32'h118; add.flush = 1'b1;
    step("flush_hz", add);
    add.flush = 1'b0;

    // Hold for three cycles with changing decode inputs, including a hazard.
    step("lw_before_hold", lw);
    for (int i = 0; i < 3; i++) begin
      s = add; s.hold = 1'b1; s.pc = 32'h200 + 32'(i * 4); s.imm = 32'(i);
      step($sformatf("hold%0d", i), s);
    end
    step("hold_release_stall", add);
    step("hold_release_capture", add);

    // Invalid decode slot: control forced to zero.
    s = add; s.valid = 1'b0; s.mr = 1'b1; s.mw = 1'b1;
    step("invalid_slot", s);

    // Randomized run.
    for (int i = 0; i < 400; i++) begin
      step($sformatf("rand%0d", i), rand_stim());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
